ysyx_25010008_bus_arbiter: RTL
==============================

# ysyx_25010008_bus_arbiter

Stateful two-master bus arbiter and address router between the core's instruction fetch unit (master 0, read-only) and load/store unit (master 1, read/write), and two slaves: the external AXI4 `io_master` port and the on-core CLINT read port. It grants one transaction at a time and alternates round-robin between the masters when both request. It routes each master-1 read by address to the CLINT or to `io_master`. Masters may request concurrently, and every handshake follows the AXI valid/ready rules.

## Interface
- `CLINT_BASE`, default 32'h0200_0000: CLINT window base.
- `CLINT_MASK`, default 32'hFFFF_0000: an address hits the CLINT when `(addr & CLINT_MASK) == CLINT_BASE`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `araddr_0`/`arvalid_0`/`arready_0`  in/in/out  32/1/1  master 0 AR channel.
- `rdata_0`/`rresp_0`/`rvalid_0`/`rready_0`  out/out/out/in  32/2/1/1  master 0 R channel.
- `araddr_1`/`arsize_1`/`arvalid_1`/`arready_1`  in/in/in/out  32/3/1/1  master 1 AR channel.
- `rdata_1`/`rresp_1`/`rvalid_1`/`rready_1`  out/out/out/in  32/2/1/1  master 1 R channel.
- `awaddr_1`/`awsize_1`/`awvalid_1`/`awready_1`  in/in/in/out  32/3/1/1  master 1 AW channel.
- `wdata_1`/`wstrb_1`/`wvalid_1`/`wready_1`  in/in/in/out  32/4/1/1  master 1 W channel.
- `bresp_1`/`bvalid_1`/`bready_1`  out/out/in  2/1/1  master 1 B channel.
- `io_master_aw*`, `io_master_w*`, `io_master_b*`, `io_master_ar*`, `io_master_r*`: AXI4 master port with the standard widths (addr 32, data 32, id 4, len 8, size 3, burst 2).
- `clint_araddr`/`clint_arvalid`/`clint_arready`  out/out/in  32/1/1  CLINT AR channel.
- `clint_rdata`/`clint_rresp`/`clint_rvalid`/`clint_rready`  in/in/in/out  32/2/1/1  CLINT R channel.

## Operation
- **State register** takes five values:
  - IDLE.
  - AR: forwarding the address phase.
  - R: waiting for read data.
  - WA: write address/data phase.
  - B: waiting for the write response.
- **Registered context:**
  - `gnt`: granted master.
  - `tgt`: CLINT or io_master.
  - `last`: master granted most recently.
  - `aw_done`, `w_done`.
- **IDLE arbitration:**
  - req0 = `arvalid_0`.
  - req1 = `arvalid_1 | awvalid_1`.
  - If only one master requests, that master is granted.
  - If both request, the master that is not `last` is granted.
  - Granting updates `gnt` and `last`.
- **Next state after a grant:**
  - Master 1 with `awvalid_1` goes to WA. A write takes precedence over a simultaneous master-1 read.
  - Otherwise go to AR.
  - `tgt` = CLINT only for a master-1 read hitting the CLINT window. Master 0 and all writes always target io_master.
- **AR:**
  - The granted master's `araddr`/`arsize` pass combinationally to `tgt`. Master 0 always uses size 3'b010.
  - `*_arvalid` to the target = the granted master's `arvalid`.
  - The granted master's `arready` = the target's `arready`.
  - On the AR handshake go to R.
- **R:**
  - Target `rdata`/`rresp`/`rvalid` pass to the granted master only.
  - Target `rready` = the granted master's `rready`.
  - On the R handshake (`rlast` ignored; single beat) go to IDLE.
- **WA:**
  - AW and W pass through independently.
  - `aw_done` and `w_done` set on their respective handshakes, and each channel's valid to io_master is masked once its done flag is set.
  - When both done flags are set (including both in the same cycle) go to B.
- **B:**
  - `bresp`/`bvalid` pass to master 1; `io_master_bready` = `bready_1`.
  - On the handshake go to IDLE and clear the done flags.
- **Constant io_master fields:**
  - `awid` = `arid` = 0.
  - `awlen` = `arlen` = 0.
  - `awburst` = `arburst` = 2'b01.
  - `wlast` = `io_master_wvalid`.
- **Non-granted master:**
  - All ready/valid outputs are 0.
  - Data outputs are driven 0.
- **Unused bid/rid:** ignored; errors in `rresp`/`bresp` pass through unmodified.

## Timing
- **Reset values (asynchronous):**
  - state = IDLE, `last` = 1 (so master 0 wins the first tie), done flags = 0.
  - All valid/ready outputs are 0 immediately on assertion.
  - Data/address outputs are 0.
- **Grant latency:** a request seen in IDLE at edge N drives downstream `arvalid`/`awvalid` in cycle N+1. There is no combinational path from request to downstream valid.
- **Minimum read:** 3 cycles from request to the R handshake with a zero-wait slave: grant, AR, R.
- **Back-to-back:** IDLE for exactly one cycle between transactions; that cycle is where the round-robin decision is made.
- **Reset mid-transaction:** abandons the transaction with no outstanding-transaction tracking. Downstream slaves share the same reset.
- **Master drops valid before ready:** this is an AXI protocol violation and is undefined. The design must not deadlock the arbiter if valid drops while in AR: stay in AR until the handshake.

## Structure
- Shared package holds:
  - State encodings (IDLE/AR/R/WA/B).
  - MASTER_0/MASTER_1 and SLAVE_CLINT/SLAVE_OTHERS constants.
  - AXI burst/size constants.
  - `CLINT_BASE`/`CLINT_MASK` defaults.
- Single flat module; no sub-module needed. The CLINT itself lives outside and connects through the `clint_*` port.

## Test plan
- **Single master-0 read:** `araddr_0` = 0x3000_0000 with io_master `arready`/`rvalid` = 1 → `io_master_araddr` = 0x3000_0000 with `arsize` = 2, `rdata_0` = slave data, and `rvalid_0` in cycle 3.
- **Contention:** `arvalid_0` and `arvalid_1` rise together after reset → master 0 is served first, then master 1. With both still requesting, grants alternate 0,1,0,1 across four transactions.
- **CLINT routing:** master-1 read of 0x0200_0048 → only `clint_arvalid` = 1, `io_master_arvalid` stays 0, and `rdata_1` = `clint_rdata`. A read of 0x0201_0000 goes to io_master.
- **Write with W before AW:** io_master `wready` = 1 and `awready` delayed 3 cycles → `io_master_wvalid` drops after its handshake, state reaches B only after AW completes, and `bvalid_1` follows `io_master_bvalid`.
- **Simultaneous aw/ar from master 1:** `awvalid_1` and `arvalid_1` both high in IDLE → the write completes first, then the read is granted.
- **Reset mid-R:** assert reset while in R → all valid/ready outputs are 0 in the same cycle, and state is IDLE after release.

Source files
------------

// File: rtl/ysyx_25010008_bus_arbiter_pkg.sv
// Shared types and constants for the two-master / two-slave bus arbiter.
// Holds state encodings, master/slave identifiers, AXI constants and the CLINT window.
package ysyx_25010008_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WA   = 3'd3,
    ST_B    = 3'd4
  } arb_state_e;

  localparam logic MASTER_0     = 1'b0;
  localparam logic MASTER_1     = 1'b1;
  localparam logic SLAVE_OTHERS = 1'b0;
  localparam logic SLAVE_CLINT  = 1'b1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_ID_ZERO    = 4'd0;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK_DEFAULT = 32'hFFFF_0000;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_25010008_bus_arbiter.sv
// Round-robin arbiter between IFU (master 0) and LSU (master 1), routing LSU reads
// to the CLINT or io_master; one single-beat transaction in flight at a time.
module ysyx_25010008_bus_arbiter
  import ysyx_25010008_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] araddr_0,
  input  logic        arvalid_0,
  output logic        arready_0,
  output logic [31:0] rdata_0,
  output logic [1:0]  rresp_0,
  output logic        rvalid_0,
  input  logic        rready_0,

  input  logic [31:0] araddr_1,
  input  logic [2:0]  arsize_1,
  input  logic        arvalid_1,
  output logic        arready_1,
  output logic [31:0] rdata_1,
  output logic [1:0]  rresp_1,
  output logic        rvalid_1,
  input  logic        rready_1,
  input  logic [31:0] awaddr_1,
  input  logic [2:0]  awsize_1,
  input  logic        awvalid_1,
  output logic        awready_1,
  input  logic [31:0] wdata_1,
  input  logic [3:0]  wstrb_1,
  input  logic        wvalid_1,
  output logic        wready_1,
  output logic [1:0]  bresp_1,
  output logic        bvalid_1,
  input  logic        bready_1,

  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,

  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready
);

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       tgt_q, tgt_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  // Single-beat reads: rlast and the response ids carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{io_master_bid, io_master_rid, io_master_rlast};

  logic        sel_arvalid, sel_rready;
  logic [31:0] sel_araddr;
  logic [2:0]  sel_arsize;
  logic        tgt_arready, tgt_rvalid;
  logic [31:0] tgt_rdata;
  logic [1:0]  tgt_rresp;
  logic        aw_hs, w_hs;
  logic        req0, req1, pick;

  assign sel_arvalid = (gnt_q == MASTER_1) ? arvalid_1 : arvalid_0;
  assign sel_rready  = (gnt_q == MASTER_1) ? rready_1  : rready_0;
  assign sel_araddr  = (gnt_q == MASTER_1) ? araddr_1  : araddr_0;
  assign sel_arsize  = (gnt_q == MASTER_1) ? arsize_1  : AXI_SIZE_4B;

  assign tgt_arready = (tgt_q == SLAVE_CLINT) ? clint_arready : io_master_arready;
  assign tgt_rvalid  = (tgt_q == SLAVE_CLINT) ? clint_rvalid  : io_master_rvalid;
  assign tgt_rdata   = (tgt_q == SLAVE_CLINT) ? clint_rdata   : io_master_rdata;
  assign tgt_rresp   = (tgt_q == SLAVE_CLINT) ? clint_rresp   : io_master_rresp;

  assign aw_hs = (state_q == ST_WA) && awvalid_1 && io_master_awready && !aw_done_q;
  assign w_hs  = (state_q == ST_WA) && wvalid_1  && io_master_wready  && !w_done_q;

  assign req0 = arvalid_0;
  assign req1 = arvalid_1 | awvalid_1;
  // On a tie the master that was not served last wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    tgt_d     = tgt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q  | w_hs;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d  = pick;
          last_d = pick;
          if (pick == MASTER_1 && awvalid_1) begin
            state_d = ST_WA;
            tgt_d   = SLAVE_OTHERS;
          end else begin
            state_d = ST_AR;
            tgt_d   = (pick == MASTER_1 && in_window(araddr_1, CLINT_BASE, CLINT_MASK))
                      ? SLAVE_CLINT : SLAVE_OTHERS;
          end
        end
      end
      ST_AR:   if (sel_arvalid && tgt_arready) state_d = ST_R;
      ST_R:    if (tgt_rvalid && sel_rready)   state_d = ST_IDLE;
      ST_WA:   if (aw_done_d && w_done_d)      state_d = ST_B;
      ST_B: begin
        if (io_master_bvalid && bready_1) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= MASTER_0;
      tgt_q     <= SLAVE_OTHERS;
      last_q    <= MASTER_1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      tgt_q     <= tgt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign io_master_awid    = AXI_ID_ZERO;
  assign io_master_arid    = AXI_ID_ZERO;
  assign io_master_awlen   = AXI_LEN_SINGLE;
  assign io_master_arlen   = AXI_LEN_SINGLE;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_wlast   = io_master_wvalid;

  always_comb begin
    arready_0 = 1'b0; rdata_0 = '0; rresp_0 = '0; rvalid_0 = 1'b0;
    arready_1 = 1'b0; rdata_1 = '0; rresp_1 = '0; rvalid_1 = 1'b0;
    awready_1 = 1'b0; wready_1 = 1'b0; bresp_1 = '0; bvalid_1 = 1'b0;
    io_master_awvalid = 1'b0; io_master_awaddr = '0; io_master_awsize = '0;
    io_master_wvalid  = 1'b0; io_master_wdata  = '0; io_master_wstrb  = '0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0; io_master_araddr = '0; io_master_arsize = '0;
    io_master_rready  = 1'b0;
    clint_araddr = '0; clint_arvalid = 1'b0; clint_rready = 1'b0;
    case (state_q)
      ST_AR: begin
        if (tgt_q == SLAVE_CLINT) begin
          clint_araddr  = sel_araddr;
          clint_arvalid = sel_arvalid;
        end else begin
          io_master_araddr  = sel_araddr;
          io_master_arsize  = sel_arsize;
          io_master_arvalid = sel_arvalid;
        end
        if (gnt_q == MASTER_1) arready_1 = tgt_arready;
        else                   arready_0 = tgt_arready;
      end
      ST_R: begin
        if (tgt_q == SLAVE_CLINT) clint_rready     = sel_rready;
        else                      io_master_rready = sel_rready;
        if (gnt_q == MASTER_1) begin
          rdata_1 = tgt_rdata; rresp_1 = tgt_rresp; rvalid_1 = tgt_rvalid;
        end else begin
          rdata_0 = tgt_rdata; rresp_0 = tgt_rresp; rvalid_0 = tgt_rvalid;
        end
      end
      ST_WA: begin
        // Each channel goes quiet once its own handshake has happened.
        io_master_awaddr  = awaddr_1;
        io_master_awsize  = awsize_1;
        io_master_awvalid = awvalid_1 & ~aw_done_q;
        awready_1         = io_master_awready & ~aw_done_q;
        io_master_wdata   = wdata_1;
        io_master_wstrb   = wstrb_1;
        io_master_wvalid  = wvalid_1 & ~w_done_q;
        wready_1          = io_master_wready & ~w_done_q;
      end
      ST_B: begin
        bresp_1          = io_master_bresp;
        bvalid_1         = io_master_bvalid;
        io_master_bready = bready_1;
      end
      default: ;
    endcase
  end

endmodule
